// File: rtl/reset_seq.sv
// Power-on / push-button reset sequencer: debounces a reset key, combines it with
// memory readiness, and releases N active-low reset outputs one at a time.
module reset_seq #(
    parameter int N   = 4,
    parameter int DLY = 1024,
    parameter int DB  = 65536,
    parameter int DIV = 50000000
) (
    input  logic         clkSYS,
    input  logic         n_reset,
    input  logic         key_n,
    input  logic         mem_ready,
    output logic [N-1:0] n_reset_out,
    output logic         busy,
    output logic         tick,
    output logic [7:0]   tick_cnt,
    input  logic         dbg_load,
    input  logic         dbg_shift,
    input  logic         dbg_din,
    output logic         dbg_dout
);

    localparam int DC_W = $clog2(DLY);
    localparam int DB_W = $clog2(DB);
    localparam int TC_W = $clog2(DIV);
    localparam int S_W  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t          state;
    logic [S_W-1:0]  s;
    logic [DC_W-1:0] dc;
    logic            key_s1;
    logic            key_s2;
    logic            key_db;
    logic [DB_W-1:0] db_cnt;
    logic [TC_W-1:0] tc;
    logic [7:0]      sr;
    logic            req;

    // Key synchroniser and debounce: key_db only follows after DB unbroken disagreeing samples.
    always_ff @(posedge clkSYS) begin
        if (!n_reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_db <= 1'b1;
            db_cnt <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            if (key_s2 != key_db) begin
                if (db_cnt == DB_W'(DB - 1)) begin
                    key_db <= key_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // mem_ready comes from the same clock domain, so it is used directly.
    assign req = ~key_db | ~mem_ready;

    always_ff @(posedge clkSYS) begin
        if (!n_reset) begin
            state       <= ST_ASSERT;
            n_reset_out <= '0;
            busy        <= 1'b1;
            s           <= '0;
            dc          <= '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    n_reset_out <= '0;
                    busy        <= 1'b1;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!req) begin
                        s     <= '0;
                        dc    <= DC_W'(DLY - 1);
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (req) begin
                        n_reset_out <= '0;
                        state       <= ST_ASSERT;
                    end else if (dc != '0) begin
                        dc <= dc - 1'b1;
                    end else begin
                        // OR-ing keeps earlier stages high, so bits can only release in order.
                        n_reset_out <= n_reset_out | (N'(1) << s);
                        if (s == S_W'(N - 1)) begin
                            busy  <= 1'b0;
                            state <= ST_RUN;
                        end else begin
                            s  <= s + 1'b1;
                            dc <= DC_W'(DLY - 1);
                        end
                    end
                end
                ST_RUN: begin
                    if (req) begin
                        n_reset_out <= '0;
                        busy        <= 1'b1;
                        state       <= ST_ASSERT;
                    end
                end
                default: begin
                    n_reset_out <= '0;
                    busy        <= 1'b1;
                    state       <= ST_ASSERT;
                end
            endcase
        end
    end

    // Free-running divider; it is never held by the sequencer state.
    always_ff @(posedge clkSYS) begin
        if (!n_reset) begin
            tc   <= TC_W'(DIV - 1);
            tick <= 1'b0;
        end else if (tc == '0) begin
            tc   <= TC_W'(DIV - 1);
            tick <= 1'b1;
        end else begin
            tc   <= tc - 1'b1;
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clkSYS) begin
        if (!n_reset) begin
            tick_cnt <= '0;
        end else if (!n_reset_out[N-1]) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Debug scan register: capture has priority over shift.
    always_ff @(posedge clkSYS) begin
        if (!n_reset) begin
            sr <= '0;
        end else if (dbg_load) begin
            sr <= tick_cnt;
        end else if (dbg_shift) begin
            sr <= {sr[6:0], dbg_din};
        end
    end

    assign dbg_dout = sr[7];

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with N=3, DLY=4, DB=3, DIV=5; expected values are
// hand-derived edge numbers counted from the first edge with n_reset high.
module tb_reset_seq;

    logic       clk;
    logic       n_reset;
    logic       key_n;
    logic       mem_ready;
    logic [2:0] n_reset_out;
    logic       busy;
    logic       tick;
    logic [7:0] tick_cnt;
    logic       dbg_load;
    logic       dbg_shift;
    logic       dbg_din;
    logic       dbg_dout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    reset_seq #(.N(3), .DLY(4), .DB(3), .DIV(5)) dut (
        .clkSYS     (clk),
        .n_reset    (n_reset),
        .key_n      (key_n),
        .mem_ready  (mem_ready),
        .n_reset_out(n_reset_out),
        .busy       (busy),
        .tick       (tick),
        .tick_cnt   (tick_cnt),
        .dbg_load   (dbg_load),
        .dbg_shift  (dbg_shift),
        .dbg_din    (dbg_din),
        .dbg_dout   (dbg_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic step_to(input int e);
        while (cyc < e) step(1);
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        step(2);
        n_reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        logic [7:0] pat;
        n_reset   = 1'b0;
        key_n     = 1'b1;
        mem_ready = 1'b1;
        dbg_load  = 1'b0;
        dbg_shift = 1'b0;
        dbg_din   = 1'b0;

        // Reset state
        step(2);
        check("rst_out",   32'(n_reset_out), 32'h0);
        check("rst_busy",  32'(busy),        32'h1);
        check("rst_tick",  32'(tick),        32'h0);
        check("rst_tcnt",  32'(tick_cnt),    32'h0);
        check("rst_dout",  32'(dbg_dout),    32'h0);
        n_reset = 1'b1;
        cyc = 0;

        // Power-up sequence: bits at edges 6, 10, 14
        step_to(5);  check("seq_e5",  32'(n_reset_out), 32'h0);
        step_to(6);  check("seq_e6",  32'(n_reset_out), 32'h1);
        step_to(9);  check("seq_e9",  32'(n_reset_out), 32'h1);
        step_to(10); check("seq_e10", 32'(n_reset_out), 32'h3);
        step_to(13); check("seq_e13", 32'(n_reset_out), 32'h3);
        check("busy_e13", 32'(busy), 32'h1);
        step_to(14); check("seq_e14", 32'(n_reset_out), 32'h7);
        check("busy_e14", 32'(busy), 32'h0);

        // Tick every 5 clocks, tick_cnt counts after full release
        step_to(15); check("tick_e15", 32'(tick), 32'h1);
        check("tcnt_e15", 32'(tick_cnt), 32'h0);
        step_to(16); check("tick_e16", 32'(tick), 32'h0);
        check("tcnt_e16", 32'(tick_cnt), 32'h1);
        step_to(20); check("tick_e20", 32'(tick), 32'h1);
        step_to(39); check("tcnt_e39", 32'(tick_cnt), 32'h5);

        // Short key glitch is filtered
        step_to(40);
        key_n = 1'b0;
        step(2);
        key_n = 1'b1;
        step_to(52);
        check("glitch_out",  32'(n_reset_out), 32'h7);
        check("glitch_busy", 32'(busy),        32'h0);

        // Long key press: key_db falls at 57, outputs drop at 58
        key_n = 1'b0;
        step_to(57); check("key_e57", 32'(n_reset_out), 32'h7);
        step_to(58); check("key_e58", 32'(n_reset_out), 32'h0);
        check("key_busy", 32'(busy), 32'h1);
        key_n = 1'b1;
        step_to(59); check("key_tcnt_clr", 32'(tick_cnt), 32'h0);
        step_to(67); check("key_e67", 32'(n_reset_out), 32'h0);
        step_to(68); check("key_e68", 32'(n_reset_out), 32'h1);

        // mem_ready drop mid-sequence aborts and restarts from bit 0
        mem_ready = 1'b0;
        step(1);
        check("mem_e69_out",  32'(n_reset_out), 32'h0);
        check("mem_e69_busy", 32'(busy),        32'h1);
        mem_ready = 1'b1;
        step_to(74); check("mem_e74", 32'(n_reset_out), 32'h0);
        step_to(75); check("mem_e75", 32'(n_reset_out), 32'h1);
        step_to(79); check("mem_e79", 32'(n_reset_out), 32'h3);
        step_to(83); check("mem_e83", 32'(n_reset_out), 32'h7);
        step_to(100); check("tcnt_e100", 32'(tick_cnt), 32'h3);

        // Fill scan register with ones, then load+shift together: load wins
        dbg_shift = 1'b1;
        dbg_din   = 1'b1;
        step(8);
        check("scan_ones", 32'(dbg_dout), 32'h1);
        check("tcnt_e108", 32'(tick_cnt), 32'h5);
        dbg_load = 1'b1;
        step(1);
        check("load_wins", 32'(dbg_dout), 32'h0);
        dbg_load = 1'b0;
        step(8);
        check("scan_ones2", 32'(dbg_dout), 32'h1);
        dbg_shift = 1'b0;
        step_to(119);

        // Forced reset in RUN with every other input disturbed
        n_reset   = 1'b0;
        key_n     = 1'b0;
        mem_ready = 1'b0;
        dbg_shift = 1'b1;
        step(1);
        check("frst_out",  32'(n_reset_out), 32'h0);
        check("frst_busy", 32'(busy),        32'h1);
        check("frst_tick", 32'(tick),        32'h0);
        check("frst_tcnt", 32'(tick_cnt),    32'h0);
        check("frst_dout", 32'(dbg_dout),    32'h0);
        key_n     = 1'b1;
        mem_ready = 1'b1;
        dbg_shift = 1'b0;
        dbg_din   = 1'b0;

        // Scan out tick_cnt = A5 (165th increment at edge 16 + 5*164 = 836)
        do_reset();
        step_to(835); check("tcnt_e835", 32'(tick_cnt), 32'hA4);
        step_to(836); check("tcnt_e836", 32'(tick_cnt), 32'hA5);
        dbg_load = 1'b1;
        step(1);
        dbg_load = 1'b0;
        pat = 8'hA5;
        check("scan_bit0", 32'(dbg_dout), 32'(pat[7]));
        dbg_shift = 1'b1;
        dbg_din   = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step(1);
            check($sformatf("scan_bit%0d", i), 32'(dbg_dout), 32'(pat[7-i]));
        end
        step(1);
        check("scan_empty", 32'(dbg_dout), 32'h0);
        dbg_shift = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset; no other clocks are used and no asynchronous reset paths exist.
REQ-002 Parameter N, default 4: number of sequenced reset outputs (1..8).
REQ-003 Parameter DLY, default 1024: clocks between successive stage releases (>=2).
REQ-004 Parameter DB, default 65536: key debounce length in clocks (>=2).
REQ-005 Parameter DIV, default 50000000: tick period in clocks (>=2).
REQ-006 clkSYS  in  1  system clock; all state updates on its rising edge.
REQ-007 n_reset  in  1  synchronous active-low reset, sampled on clkSYS.
REQ-008 key_n  in  1  asynchronous push-button, low = reset request.
REQ-009 mem_ready  in  1  memory subsystem ready, low = reset request.
REQ-010 n_reset_out  out  N  sequenced active-low resets, bit 0 released first.
REQ-011 busy  out  1  high whenever the state is not RUN.
REQ-012 tick  out  1  one-clock pulse every DIV clocks.
REQ-013 tick_cnt  out  8  count of ticks since the last full release.
REQ-014 dbg_load, dbg_shift  in  1 each  debug scan capture and shift strobes.
REQ-015 dbg_din  in  1 / dbg_dout  out  1  debug scan chain serial in/out.

Function
REQ-016 key_n SHALL pass through a 2-flop synchroniser; key_db SHALL change to the synchronised value only after it has differed from key_db for DB consecutive clocks; any agreement restarts the count.
REQ-017 req = ~key_db | ~mem_ready; mem_ready is used unsynchronised (same clock domain).
REQ-018 States: ASSERT, WAIT, RELEASE, RUN; stage index s in 0..N-1; delay counter dc, width clog2(DLY).
REQ-019 ASSERT: all n_reset_out = 0; next state WAIT unconditionally.
REQ-020 WAIT: if req, stay; else s <= 0, dc <= DLY-1, go RELEASE.
REQ-021 RELEASE with req high: all n_reset_out <= 0, go ASSERT (abort mid-sequence).
REQ-022 RELEASE, no req, dc != 0: dc <= dc-1.
REQ-023 RELEASE, no req, dc == 0: n_reset_out[s] <= 1; if s == N-1 go RUN, else s <= s+1, dc <= DLY-1.
REQ-024 RUN with req high: on the same edge all n_reset_out <= 0 and state <= ASSERT.
REQ-025 Released bits SHALL stay high until the next ASSERT; bits never release out of order.
REQ-026 Tick counter tc counts DIV-1 down to 0 and wraps to DIV-1; tick SHALL be registered high for the one clock following the edge where tc == 0; tc runs in every state.
REQ-027 tick_cnt SHALL hold 0 while n_reset_out[N-1] is 0, else increment on each tick, wrapping 255 -> 0.
REQ-028 8-bit scan register sr: dbg_load sets sr <= tick_cnt; else dbg_shift sets sr <= {sr[6:0], dbg_din}; load has priority; dbg_dout = sr[7] combinationally.

Reset
REQ-029 While n_reset is low: state ASSERT, n_reset_out all 0, busy 1, s 0, dc 0, synchroniser flops and key_db 1, debounce count 0, tc DIV-1, tick 0, tick_cnt 0, sr 0.
REQ-030 n_reset low mid-sequence or in RUN SHALL force the reset values on the next edge regardless of other inputs.

Verification (N=3, DLY=4, DB=3, DIV=5)
REQ-031 n_reset high at edge 1, key_n=1, mem_ready=1 -> n_reset_out[0] rises at edge 6, [1] at edge 10, [2] at edge 14; busy falls at edge 14.
REQ-032 In RUN, key_n low for 2 clocks then high -> no reset; key_n low for 6 clocks -> all outputs 0 one edge after key_db falls, then resequence after release.
REQ-033 mem_ready low for 1 clock while n_reset_out = 3'b001 -> all outputs 0 next edge, state ASSERT, sequence restarts from bit 0.
REQ-034 Free run 25 clocks after full release -> tick pulses every 5 clocks, tick_cnt = 5; a forced reset clears tick_cnt to 0.
REQ-035 tick_cnt = 8'hA5, dbg_load then 8 dbg_shift pulses with dbg_din = 0 -> dbg_dout emits 1,0,1,0,0,1,0,1 and sr ends 0; load and shift together -> load wins.
